// File: rtl/fetch_unit.sv
// Fetch stage ahead of the 4-wide I-cache: issues four consecutive word PCs per
// cycle, tags the one-cycle cache response, and buffers bundles for decode.
module fetch_unit #(
  parameter logic [14:0] RESET_PC = 15'h0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [59:0] pc_array_flat,
  input  logic [63:0] instructions_flat,
  input  logic        redirect_valid,
  input  logic [14:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [63:0] dec_instrs_flat,
  output logic [14:0] dec_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QDEPTH_C = (CW + 1)'(QDEPTH);

  logic [14:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_valid_q, inflight_valid_d;
  logic [14:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [14:0]   mem_pc_q    [QDEPTH];
  logic [63:0]   mem_instr_q [QDEPTH];

  logic [CW:0] credit;
  logic        issue;
  logic        push;
  logic        pop;

  // The cache has no enable, so the fetch address is presented every cycle.
  assign pc_array_flat = {fetch_pc_q, fetch_pc_q + 15'd1, fetch_pc_q + 15'd2, fetch_pc_q + 15'd3};

  // Decode handshake: a bundle transfers on a cycle where dec_valid && dec_ready,
  // unless a redirect in that same cycle flushes the queue instead.
  assign dec_valid       = (count_q != '0);
  assign dec_pc          = mem_pc_q[rd_ptr_q];
  assign dec_instrs_flat = mem_instr_q[rd_ptr_q];

  always_comb begin
    credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_valid_q};
    // Same-cycle pops are not credited, keeping the push path free of overflow.
    issue  = !redirect_valid && (credit < QDEPTH_C);
    push   = inflight_valid_q && !redirect_valid;
    pop    = dec_valid && dec_ready && !redirect_valid;

    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_valid_d = 1'b1;
        inflight_pc_d    = fetch_pc_q;
        fetch_pc_d       = fetch_pc_q + 15'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage is reset so the decode outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
      mem_instr_q[wr_ptr_q] <= instructions_flat;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a cache model feeds address-derived words, and a
// queue-based reference model predicts every bundle decode should receive.
module tb_fetch_unit;

  localparam logic [14:0] RESET_PC = 15'h0000;
  localparam int          QDEPTH   = 4;

  logic        clk;
  logic        rst_n;
  logic [59:0] pc_array_flat;
  logic [63:0] instructions_flat;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_instrs_flat;
  logic [14:0] dec_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_array_flat    (pc_array_flat),
    .instructions_flat(instructions_flat),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_instrs_flat  (dec_instrs_flat),
    .dec_pc           (dec_pc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [15:0] word(logic [14:0] a);
    return {1'b1, a} ^ 16'h3C5A;
  endfunction

  function automatic logic [59:0] exp_pcs(logic [14:0] f);
    return {f, 15'(f + 15'd1), 15'(f + 15'd2), 15'(f + 15'd3)};
  endfunction

  function automatic logic [63:0] bundle(logic [14:0] p);
    return {word(p), word(15'(p + 15'd1)), word(15'(p + 15'd2)), word(15'(p + 15'd3))};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache model: returns the words of the PCs sampled one edge earlier.
  always @(posedge clk)
    instructions_flat <= {word(pc_array_flat[59:45]), word(pc_array_flat[44:30]),
                          word(pc_array_flat[29:15]), word(pc_array_flat[14:0])};

  // ---------------- reference model ----------------
  // exp_q holds the PCs of bundles that should be sitting in the decode queue.
  logic [14:0] exp_q[$];
  logic [14:0] m_fetch;
  logic        m_inf;
  logic [14:0] m_inf_pc;
  int          m_pops;

  always @(posedge clk or negedge rst_n) begin
    int occ;
    if (!rst_n) begin
      m_fetch  = RESET_PC;
      m_inf    = 1'b0;
      m_inf_pc = '0;
      m_pops   = 0;
      exp_q.delete();
    end else if (redirect_valid) begin
      m_fetch = redirect_pc;
      m_inf   = 1'b0;
      m_pops  = 0;
      exp_q.delete();
    end else begin
      occ = exp_q.size() + m_pops;
      if (m_inf) exp_q.push_back(m_inf_pc);
      if (occ + int'(m_inf) < QDEPTH) begin
        m_inf_pc = m_fetch;
        m_inf    = 1'b1;
        m_fetch  = m_fetch + 15'd4;
      end else begin
        m_inf = 1'b0;
      end
      m_pops = 0;
    end
  end

  // ---------------- monitor ----------------
  logic [14:0] mon_pc;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("pc_array", 64'(pc_array_flat), 64'(exp_pcs(m_fetch)));
      check("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && dec_ready && !redirect_valid) begin
        mon_pc = exp_q.pop_front();
        m_pops++;
        check("dec_pc", 64'(dec_pc), 64'(mon_pc));
        check("dec_instrs", dec_instrs_flat, bundle(mon_pc));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [14:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset dec_valid", 64'(dec_valid), 64'(0));
    check("reset dec_pc", 64'(dec_pc), 64'(0));
    check("reset dec_instrs", dec_instrs_flat, 64'(0));
    check("reset pc_array", 64'(pc_array_flat), 64'({15'd0, 15'd1, 15'd2, 15'd3}));

    // Streaming from reset with decode always ready.
    dec_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("first pcs", 64'(pc_array_flat), 64'({15'd0, 15'd1, 15'd2, 15'd3}));
    step();
    @(negedge clk);
    check("second pcs", 64'(pc_array_flat), 64'({15'd4, 15'd5, 15'd6, 15'd7}));
    check("no bypass", 64'(dec_valid), 64'(0));
    step();
    @(negedge clk);
    check("first valid", 64'(dec_valid), 64'(1));
    check("first dec_pc", 64'(dec_pc), 64'(15'h0000));
    step();
    @(negedge clk);
    check("second dec_pc", 64'(dec_pc), 64'(15'h0004));
    repeat (8) step();

    // Backpressure from reset: queue fills to QDEPTH, fetch stalls at 16.
    dec_ready = 1'b0;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    check("stall fetch_pc", 64'(pc_array_flat[59:45]), 64'(15'd16));
    check("stall head", 64'(dec_pc), 64'(15'h0000));
    step();
    dec_ready = 1'b1;
    repeat (10) step();

    // Redirect with three queued bundles and one in flight.
    dec_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(exp_q.size() == 3 && m_inf) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL wait_q3: model never reached 3 queued plus 1 in flight");
    end
    redirect_to(15'h0100);
    @(negedge clk);
    check("flush r+1", 64'(dec_valid), 64'(0));
    step();
    @(negedge clk);
    check("flush r+2", 64'(dec_valid), 64'(0));
    step();
    @(negedge clk);
    check("refill r+3", 64'(dec_valid), 64'(1));
    check("refill pc", 64'(dec_pc), 64'(15'h0100));
    step();
    dec_ready = 1'b1;
    repeat (6) step();

    // Redirect near the top of the address space: PCs wrap.
    redirect_to(15'h7FFE);
    @(negedge clk);
    check("wrap pcs", 64'(pc_array_flat), 64'({15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001}));
    step();
    step();
    @(negedge clk);
    check("wrap head0", 64'(dec_pc), 64'(15'h7FFE));
    step();
    @(negedge clk);
    check("wrap head1", 64'(dec_pc), 64'(15'h0002));
    repeat (4) step();

    // Redirect in a cycle where decode is also popping.
    redirect_to(15'h0200);
    @(negedge clk);
    check("pop+redirect empty", 64'(dec_valid), 64'(0));
    repeat (6) step();

    // Random traffic: backpressure and redirects, including back-to-back ones.
    for (int i = 0; i < 500; i++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 15'($urandom_range(0, 32767));
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset with a full queue.
    dec_ready = 1'b0;
    repeat (8) step();
    @(negedge clk);
    check("full before reset", 64'(dec_valid), 64'(1));
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async dec_valid", 64'(dec_valid), 64'(0));
    check("async dec_pc", 64'(dec_pc), 64'(0));
    check("async dec_instrs", dec_instrs_flat, 64'(0));
    check("async pc_array", 64'(pc_array_flat), 64'({15'd0, 15'd1, 15'd2, 15'd3}));
    step();
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    @(negedge clk);
    check("restart pc", 64'(pc_array_flat[59:45]), 64'(RESET_PC));
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
